// File: rtl/life_grid_seq.sv
//==============================================================================
// Module   : life_grid_seq
// Brief    : Time-multiplexed Game-of-Life sequencer over a toroidal W x H
//            register grid. One rule evaluator visits one cell per clock in
//            row-major order, writing a shadow buffer that is committed once
//            per generation.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module life_grid_seq #(
  parameter int W     = 8,
  parameter int H     = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_en,
  input  logic [$clog2(H)-1:0] i_load_addr,
  input  logic [W-1:0]         i_load_data,
  input  logic                 i_start,
  input  logic [GEN_W-1:0]     i_num_gens,
  input  logic                 i_halt,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [GEN_W-1:0]     o_gen_done,
  input  logic [$clog2(H)-1:0] i_rd_addr,
  output logic [W-1:0]         o_rd_data
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(H - 1);
  localparam logic [CW-1:0] c_COL_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_cur    [H];
  logic [W-1:0]     r_shadow [H];
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [GEN_W-1:0] r_gen_done;
  logic [GEN_W-1:0] r_target;

  logic [RW-1:0]    w_rm, w_rp;
  logic [CW-1:0]    w_cm, w_cp;
  logic [3:0]       w_count;
  logic             w_self;
  logic             w_next;
  logic [GEN_W-1:0] w_gen_inc;

  // Toroidal neighbour coordinates of the cursor cell
  always_comb begin
    w_rm = (r_row == '0)         ? c_ROW_LAST : r_row - 1'b1;
    w_rp = (r_row == c_ROW_LAST) ? '0         : r_row + 1'b1;
    w_cm = (r_col == '0)         ? c_COL_LAST : r_col - 1'b1;
    w_cp = (r_col == c_COL_LAST) ? '0         : r_col + 1'b1;
  end

  // Shared rule evaluator: neighbour count and next state from the committed grid
  always_comb begin
    w_count = 4'd0;
    w_count = w_count + {3'b0, r_cur[w_rm][w_cm]};
    w_count = w_count + {3'b0, r_cur[w_rm][r_col]};
    w_count = w_count + {3'b0, r_cur[w_rm][w_cp]};
    w_count = w_count + {3'b0, r_cur[r_row][w_cm]};
    w_count = w_count + {3'b0, r_cur[r_row][w_cp]};
    w_count = w_count + {3'b0, r_cur[w_rp][w_cm]};
    w_count = w_count + {3'b0, r_cur[w_rp][r_col]};
    w_count = w_count + {3'b0, r_cur[w_rp][w_cp]};
    w_self  = r_cur[r_row][r_col];
    w_next  = (w_count == 4'd3) | (w_self & (w_count == 4'd2));
  end

  assign w_gen_inc  = r_gen_done + GEN_W'(1);
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_gen_done = r_gen_done;
  assign o_rd_data  = r_cur[i_rd_addr];

  // Sequencer FSM with grid, shadow, cursor and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_gen_done <= '0;
      r_target   <= '0;
      for (int i = 0; i < H; i++) begin
        r_cur[i]    <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_load_en) begin
            r_cur[i_load_addr] <= i_load_data;
          end
          if (i_start) begin
            r_target   <= i_num_gens;
            r_gen_done <= '0;
            r_row      <= '0;
            r_col      <= '0;
            if (i_num_gens != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          r_shadow[r_row][r_col] <= w_next;
          if (i_halt) begin
            // Abandon the partial generation; the shadow is simply ignored
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
          end else if (r_col == c_COL_LAST) begin
            r_col <= '0;
            if (r_row == c_ROW_LAST) begin
              r_row   <= '0;
              r_state <= S_COMMIT;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end

        S_COMMIT: begin
          for (int i = 0; i < H; i++) begin
            r_cur[i] <= r_shadow[i];
          end
          r_gen_done <= w_gen_inc;
          if (i_halt) begin
            // The commit of a completed generation is kept even when halting
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_gen_inc == r_target) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
